// File: rtl/ll_rd_ctrl_v2.sv
// Linked-list read controller: walks a list from a head pointer, finding a node by index or by key.
// Optional LL_RD_STATS_EN adds a saturating counter of not-found responses (rd_ctrl_miss_cnt).
module ll_rd_ctrl_v2 #(
    parameter int                 DATAMEM_WIDTH = 8,
    parameter int                 PTR_WD        = 5,
    parameter int                 LL_DEPTH      = 32,
    parameter logic [PTR_WD-1:0]  NULL_PTR      = {PTR_WD{1'b1}}
) (
    input  logic                     clk,
    input  logic                     reset_n,
    output logic                     rd_ctrl_ready,
    input  logic                     rd_ctrl_req,
    input  logic [PTR_WD-1:0]        rd_ctrl_head_ptr,
    input  logic                     rd_ctrl_mode,
    input  logic [PTR_WD-1:0]        rd_ctrl_idx,
    input  logic [DATAMEM_WIDTH-1:0] rd_ctrl_key,
    output logic                     rd_ctrl_rsp_vld,
    output logic                     rd_ctrl_rsp_found,
    output logic [DATAMEM_WIDTH-1:0] rd_ctrl_rsp_data,
    output logic [PTR_WD-1:0]        rd_ctrl_rsp_ndptr,
    output logic [PTR_WD-1:0]        rd_ctrl_rsp_nxtptr,
    output logic [PTR_WD-1:0]        rd_ctrl_rsp_prevptr,
    output logic [PTR_WD-1:0]        rd_ctrl_rsp_idx,
    input  logic                     rd_ctrl_rsp_taken,
`ifdef LL_RD_STATS_EN
    output logic [15:0]              rd_ctrl_miss_cnt,
`endif
    output logic                     data_mem_rd_vld,
    output logic [PTR_WD-1:0]        data_mem_rd_addr,
    input  logic [DATAMEM_WIDTH-1:0] data_mem_rd_data,
    input  logic                     data_mem_rd_done,
    output logic                     nxtptr_mem_rd_vld,
    output logic [PTR_WD-1:0]        nxtptr_mem_rd_addr,
    input  logic [PTR_WD-1:0]        nxtptr_mem_rd_data,
    input  logic                     nxtptr_mem_rd_done
);

    typedef enum logic [1:0] {IDLE, RD_NODE, EVAL, RESP} state_t;

    localparam logic [PTR_WD-1:0] LAST_POS = PTR_WD'(LL_DEPTH - 1);

    state_t                     state;
    logic [PTR_WD-1:0]          cur_ptr, prev_ptr, nxt_ptr, pos, idx_q;
    logic                       mode_q, null_head;
    logic [DATAMEM_WIDTH-1:0]   key_q, data_q;
    logic                       data_got, nxt_got;

    logic data_hit, nxt_hit, data_ok, nxt_ok, match, stop;

    // A done is only meaningful while its own request is outstanding.
    assign data_hit = data_mem_rd_vld & data_mem_rd_done;
    assign nxt_hit  = nxtptr_mem_rd_vld & nxtptr_mem_rd_done;
    assign data_ok  = data_got | data_hit;
    assign nxt_ok   = nxt_got | nxt_hit;
    assign match    = mode_q ? (data_q == key_q) : (pos == idx_q);
    assign stop     = match | (nxt_ptr == NULL_PTR) | (pos == LAST_POS);

    // NOTE: reset is synchronous here, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state               <= IDLE;
            rd_ctrl_ready       <= 1'b1;
            rd_ctrl_rsp_vld     <= 1'b0;
            rd_ctrl_rsp_found   <= 1'b0;
            rd_ctrl_rsp_data    <= '0;
            rd_ctrl_rsp_ndptr   <= '0;
            rd_ctrl_rsp_nxtptr  <= '0;
            rd_ctrl_rsp_prevptr <= '0;
            rd_ctrl_rsp_idx     <= '0;
            data_mem_rd_vld     <= 1'b0;
            data_mem_rd_addr    <= '0;
            nxtptr_mem_rd_vld   <= 1'b0;
            nxtptr_mem_rd_addr  <= '0;
            cur_ptr             <= '0;
            prev_ptr            <= NULL_PTR;
            nxt_ptr             <= '0;
            pos                 <= '0;
            idx_q               <= '0;
            mode_q              <= 1'b0;
            null_head           <= 1'b0;
            key_q               <= '0;
            data_q              <= '0;
            data_got            <= 1'b0;
            nxt_got             <= 1'b0;
`ifdef LL_RD_STATS_EN
            rd_ctrl_miss_cnt    <= '0;
`endif
        end else begin
            // NOTE: every state register uses non-blocking assignment so all updates see pre-edge values.
            case (state)
                IDLE: begin
                    if (rd_ctrl_req) begin
                        mode_q        <= rd_ctrl_mode;
                        idx_q         <= rd_ctrl_idx;
                        key_q         <= rd_ctrl_key;
                        cur_ptr       <= rd_ctrl_head_ptr;
                        prev_ptr      <= NULL_PTR;
                        pos           <= '0;
                        data_got      <= 1'b0;
                        nxt_got       <= 1'b0;
                        rd_ctrl_ready <= 1'b0;
                        null_head     <= (rd_ctrl_head_ptr == NULL_PTR);
                        // An empty list still passes through EVAL, giving it a fixed one-cycle decision slot.
                        if (rd_ctrl_head_ptr == NULL_PTR) begin
                            state <= EVAL;
                        end else begin
                            state              <= RD_NODE;
                            data_mem_rd_vld    <= 1'b1;
                            data_mem_rd_addr   <= rd_ctrl_head_ptr;
                            nxtptr_mem_rd_vld  <= 1'b1;
                            nxtptr_mem_rd_addr <= rd_ctrl_head_ptr;
                        end
                    end
                end
                RD_NODE: begin
                    if (data_hit) begin
                        data_q          <= data_mem_rd_data;
                        data_mem_rd_vld <= 1'b0;
                        data_got        <= 1'b1;
                    end
                    if (nxt_hit) begin
                        nxt_ptr           <= nxtptr_mem_rd_data;
                        nxtptr_mem_rd_vld <= 1'b0;
                        nxt_got           <= 1'b1;
                    end
                    if (data_ok && nxt_ok) state <= EVAL;
                end
                EVAL: begin
                    if (null_head) begin
                        state               <= RESP;
                        rd_ctrl_rsp_vld     <= 1'b1;
                        rd_ctrl_rsp_found   <= 1'b0;
                        rd_ctrl_rsp_data    <= '0;
                        rd_ctrl_rsp_ndptr   <= NULL_PTR;
                        rd_ctrl_rsp_nxtptr  <= NULL_PTR;
                        rd_ctrl_rsp_prevptr <= NULL_PTR;
                        rd_ctrl_rsp_idx     <= '0;
                    end else if (stop) begin
                        state               <= RESP;
                        rd_ctrl_rsp_vld     <= 1'b1;
                        rd_ctrl_rsp_found   <= match;
                        rd_ctrl_rsp_data    <= match ? data_q : '0;
                        rd_ctrl_rsp_ndptr   <= cur_ptr;
                        rd_ctrl_rsp_nxtptr  <= nxt_ptr;
                        rd_ctrl_rsp_prevptr <= prev_ptr;
                        rd_ctrl_rsp_idx     <= pos;
                    end else begin
                        state              <= RD_NODE;
                        prev_ptr           <= cur_ptr;
                        cur_ptr            <= nxt_ptr;
                        pos                <= pos + 1'b1;
                        data_got           <= 1'b0;
                        nxt_got            <= 1'b0;
                        data_mem_rd_vld    <= 1'b1;
                        data_mem_rd_addr   <= nxt_ptr;
                        nxtptr_mem_rd_vld  <= 1'b1;
                        nxtptr_mem_rd_addr <= nxt_ptr;
                    end
                end
                RESP: begin
                    if (rd_ctrl_rsp_taken) begin
`ifdef LL_RD_STATS_EN
                        if (!rd_ctrl_rsp_found && rd_ctrl_miss_cnt != 16'hFFFF)
                            rd_ctrl_miss_cnt <= rd_ctrl_miss_cnt + 16'd1;
`endif
                        state               <= IDLE;
                        rd_ctrl_ready       <= 1'b1;
                        rd_ctrl_rsp_vld     <= 1'b0;
                        rd_ctrl_rsp_found   <= 1'b0;
                        rd_ctrl_rsp_data    <= '0;
                        rd_ctrl_rsp_ndptr   <= '0;
                        rd_ctrl_rsp_nxtptr  <= '0;
                        rd_ctrl_rsp_prevptr <= '0;
                        rd_ctrl_rsp_idx     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
